ram_program_loader: RTL and testbench

- Upstream of the 16-byte RAM and the input/MAR stage.
- Lets an external host load a program byte-by-byte through the input pins while the CPU is held, then releases the CPU with a one-cycle restart pulse so the program counter and control sequencer begin at address 0.
- Provides RAM address, data and write strobe directly; the top level muxes these over the MAR path while cpu_hold=1.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/input_synchronizer.sv | 34 +++
 rtl/ram_program_loader.sv | 160 ++++++++++++++++
 tb/tb_ram_program_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and defaults for the RAM program loader
// Purpose: loader FSM state encoding and default RAM geometry.
// Ports: none (package).
package cpu_pkg;

   localparam int RAM_BYTES_DEFAULT = 16;
   localparam int ADDR_W_DEFAULT    = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WRITE,
      FINISH,
      RELEASE
   } loader_state_e;

endpackage

// File: rtl/input_synchronizer.sv
// rtl/input_synchronizer.sv - multi-stage flop synchronizer for one async pin
// Purpose: bring an asynchronous level into the clk domain.
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-high reset, clears the chain to 0
//   d_async - asynchronous input level
//   q_sync  - level after STAGES flops
module input_synchronizer #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_async,
   output logic q_sync
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d_async};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_sync = sync_q[STAGES-1];

endmodule

// File: rtl/ram_program_loader.sv
// rtl/ram_program_loader.sv - host byte loader for the CPU RAM with CPU hold/restart
// Purpose: while ext_prog is held, each ext_strobe rising edge writes ext_data
//   to the next RAM address; on leaving program mode the CPU is released with a
//   one-cycle restart pulse.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   ext_prog            - async level, 1 requests program mode
//   ext_strobe          - async pin, each rising edge writes one byte
//   ext_data[7:0]       - program byte, stable around the strobe
//   ram_addr[ADDR_W-1:0]- current write address
//   ram_data[7:0]       - registered byte to write
//   ram_we              - one-cycle write pulse
//   cpu_hold            - CPU frozen while loading
//   cpu_restart         - one-cycle pulse when leaving program mode
//   done                - sticky session-complete flag
//   byte_count[ADDR_W:0]- bytes written in the current or last session
module ram_program_loader
   import cpu_pkg::*;
#(
   parameter int RAM_BYTES   = RAM_BYTES_DEFAULT,
   parameter int ADDR_W      = ADDR_W_DEFAULT,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ext_prog,
   input  logic              ext_strobe,
   input  logic [7:0]        ext_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_data,
   output logic              ram_we,
   output logic              cpu_hold,
   output logic              cpu_restart,
   output logic              done,
   output logic [ADDR_W:0]   byte_count
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W+1)'(RAM_BYTES-1);

   logic prog_s;
   logic strobe_s;
   logic rise;

   loader_state_e     state_q, state_d;
   logic              strobe_d_q, strobe_d_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [7:0]        ram_data_q, ram_data_d;
   logic              ram_we_q, ram_we_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              cpu_restart_q, cpu_restart_d;
   logic              done_q, done_d;
   logic [ADDR_W:0]   byte_count_q, byte_count_d;

   input_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_prog (
      .clk     (clk),
      .rst     (rst),
      .d_async (ext_prog),
      .q_sync  (prog_s)
   );

   input_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_strobe (
      .clk     (clk),
      .rst     (rst),
      .d_async (ext_strobe),
      .q_sync  (strobe_s)
   );

   assign rise = strobe_s & ~strobe_d_q;

   always_comb begin
      state_d       = state_q;
      strobe_d_d    = strobe_s;
      ram_addr_d    = ram_addr_q;
      ram_data_d    = ram_data_q;
      ram_we_d      = 1'b0;
      cpu_hold_d    = cpu_hold_q;
      cpu_restart_d = 1'b0;
      done_d        = done_q;
      byte_count_d  = byte_count_q;

      unique case (state_q)
         IDLE: begin
            if (prog_s) begin
               state_d      = LOAD;
               ram_addr_d   = '0;
               byte_count_d = '0;
               done_d       = 1'b0;
               cpu_hold_d   = 1'b1;
            end
         end
         LOAD: begin
            // A byte arriving together with prog falling is still written.
            if (rise) begin
               ram_data_d = ext_data;
               ram_we_d   = 1'b1;
               state_d    = WRITE;
            end else if (!prog_s) begin
               state_d = FINISH;
            end
         end
         WRITE: begin
            ram_addr_d   = ram_addr_q + ADDR_ONE;
            byte_count_d = byte_count_q + CNT_ONE;
            if (byte_count_q == LAST_CNT || !prog_s) begin
               state_d = FINISH;
            end else begin
               state_d = LOAD;
            end
         end
         FINISH: begin
            cpu_hold_d    = 1'b0;
            cpu_restart_d = 1'b1;
            done_d        = 1'b1;
            state_d       = RELEASE;
         end
         RELEASE: begin
            // Wait for prog to drop so a full-memory finish cannot re-enter LOAD.
            if (!prog_s) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         strobe_d_q    <= 1'b0;
         ram_addr_q    <= '0;
         ram_data_q    <= '0;
         ram_we_q      <= 1'b0;
         cpu_hold_q    <= 1'b0;
         cpu_restart_q <= 1'b0;
         done_q        <= 1'b0;
         byte_count_q  <= '0;
      end else begin
         state_q       <= state_d;
         strobe_d_q    <= strobe_d_d;
         ram_addr_q    <= ram_addr_d;
         ram_data_q    <= ram_data_d;
         ram_we_q      <= ram_we_d;
         cpu_hold_q    <= cpu_hold_d;
         cpu_restart_q <= cpu_restart_d;
         done_q        <= done_d;
         byte_count_q  <= byte_count_d;
      end
   end

   assign ram_addr    = ram_addr_q;
   assign ram_data    = ram_data_q;
   assign ram_we      = ram_we_q;
   assign cpu_hold    = cpu_hold_q;
   assign cpu_restart = cpu_restart_q;
   assign done        = done_q;
   assign byte_count  = byte_count_q;

endmodule

// File: tb/tb_ram_program_loader.sv
// tb/tb_ram_program_loader.sv - self-checking bench for ram_program_loader
module tb_ram_program_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       ext_prog;
   logic       ext_strobe;
   logic [7:0] ext_data;
   logic [3:0] ram_addr;
   logic [7:0] ram_data;
   logic       ram_we;
   logic       cpu_hold;
   logic       cpu_restart;
   logic       done;
   logic [4:0] byte_count;

   int errors = 0;
   int checks = 0;

   ram_program_loader dut (
      .clk         (clk),
      .rst         (rst),
      .ext_prog    (ext_prog),
      .ext_strobe  (ext_strobe),
      .ext_data    (ext_data),
      .ram_addr    (ram_addr),
      .ram_data    (ram_data),
      .ram_we      (ram_we),
      .cpu_hold    (cpu_hold),
      .cpu_restart (cpu_restart),
      .done        (done),
      .byte_count  (byte_count)
   );

   always #5 clk = ~clk;

   // Observed writes and restart pulses, sampled on the falling edge.
   logic [11:0] wr_q[$];
   int restart_cnt;
   int cur_run;
   int max_run;

   always @(negedge clk) begin
      if (!rst) begin
         if (ram_we) wr_q.push_back({ram_addr, ram_data});
         if (cpu_restart) begin
            restart_cnt = restart_cnt + 1;
            cur_run     = cur_run + 1;
         end else if (cur_run > 0) begin
            if (cur_run > max_run) max_run = cur_run;
            cur_run = 0;
         end
      end
   end

   typedef struct {
      int         n;
      logic [7:0] base;
      logic [7:0] step;
      bit         sim_last;
      int         exp_writes;
   } vec_t;

   vec_t       vecs[4];
   logic [7:0] stim_q[$];

   task automatic check(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic clear_mon();
      wr_q.delete();
      restart_cnt = 0;
      cur_run     = 0;
      max_run     = 0;
   endtask

   task automatic strobe_byte(input logic [7:0] d, input int hi, input int lo);
      ext_data   = d;
      ext_strobe = 1'b1;
      cyc(hi);
      ext_strobe = 1'b0;
      cyc(lo);
   endtask

   // One program session using stim_q; the model is: the first min(n,16)
   // bytes land at addresses 0,1,2... and the session ends with one restart.
   task automatic run_session(input string tag, input bit sim_last,
                              input bit rnd_timing, input int exp_writes);
      int hi;
      int lo;
      int nw;
      clear_mon();
      ext_prog = 1'b1;
      cyc(4);
      check({tag, "_hold_on"}, int'(cpu_hold), 1);
      check({tag, "_done_clr"}, int'(done), 0);
      check({tag, "_cnt_clr"}, int'(byte_count), 0);
      for (int i = 0; i < stim_q.size(); i++) begin
         hi = rnd_timing ? int'($urandom_range(1, 3)) : 3;
         lo = (5 - hi) + (rnd_timing ? int'($urandom_range(0, 2)) : 1);
         if (sim_last && i == stim_q.size() - 1) begin
            ext_data   = stim_q[i];
            ext_strobe = 1'b1;
            ext_prog   = 1'b0;
            cyc(hi);
            ext_strobe = 1'b0;
            cyc(lo);
         end else begin
            strobe_byte(stim_q[i], hi, lo);
         end
      end
      if (stim_q.size() > 16) begin
         cyc(6);
         check({tag, "_full_hold"}, int'(cpu_hold), 0);
         check({tag, "_full_done"}, int'(done), 1);
         check({tag, "_full_rst"}, restart_cnt, 1);
      end
      ext_prog = 1'b0;
      cyc(8);
      nw = wr_q.size();
      check({tag, "_nwrites"}, nw, exp_writes);
      for (int i = 0; i < nw && i < exp_writes; i++) begin
         check({tag, "_addr"}, int'(wr_q[i][11:8]), i);
         check({tag, "_data"}, int'(wr_q[i][7:0]), int'(stim_q[i]));
      end
      check({tag, "_count"}, int'(byte_count), exp_writes);
      check({tag, "_done"}, int'(done), 1);
      check({tag, "_restarts"}, restart_cnt, 1);
      check({tag, "_restart_w"}, max_run, 1);
      check({tag, "_hold_off"}, int'(cpu_hold), 0);
      check({tag, "_addr_end"}, int'(ram_addr), exp_writes % 16);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_addr"}, int'(ram_addr), 0);
      check({tag, "_data"}, int'(ram_data), 0);
      check({tag, "_we"}, int'(ram_we), 0);
      check({tag, "_hold"}, int'(cpu_hold), 0);
      check({tag, "_restart"}, int'(cpu_restart), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_count"}, int'(byte_count), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      bit seen;
      int n;

      vecs[0] = '{n: 3,  base: 8'h1A, step: 8'h11, sim_last: 1'b0, exp_writes: 3};
      vecs[1] = '{n: 0,  base: 8'h00, step: 8'h00, sim_last: 1'b0, exp_writes: 0};
      vecs[2] = '{n: 17, base: 8'h00, step: 8'h01, sim_last: 1'b0, exp_writes: 16};
      vecs[3] = '{n: 3,  base: 8'h53, step: 8'h01, sim_last: 1'b1, exp_writes: 3};

      rst        = 1'b1;
      ext_prog   = 1'b0;
      ext_strobe = 1'b0;
      ext_data   = 8'h00;
      clear_mon();
      cyc(3);
      check_all_zero("reset");
      rst = 1'b0;
      cyc(2);

      // Asynchronous reset while the FSM is in WRITE on the 4th byte.
      clear_mon();
      ext_prog = 1'b1;
      cyc(4);
      strobe_byte(8'h11, 3, 3);
      strobe_byte(8'h22, 3, 3);
      strobe_byte(8'h33, 3, 3);
      check("midrst_cnt3", int'(byte_count), 3);
      ext_data   = 8'h77;
      ext_strobe = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (ram_we) seen = 1'b1;
      end
      check("midrst_we_seen", int'(seen), 1);
      rst = 1'b1;
      #1;
      check_all_zero("midrst_async");
      ext_strobe = 1'b0;
      ext_prog   = 1'b0;
      cyc(2);
      rst = 1'b0;
      clear_mon();
      cyc(5);
      check("midrst_idle_hold", int'(cpu_hold), 0);
      check("midrst_idle_done", int'(done), 0);
      check("midrst_idle_cnt", int'(byte_count), 0);
      check("midrst_idle_restart", restart_cnt, 0);

      // Table-driven sessions: basic, zero-byte, full wrap, simultaneous.
      for (int v = 0; v < 4; v++) begin
         stim_q.delete();
         for (int i = 0; i < vecs[v].n; i++)
            stim_q.push_back(8'(vecs[v].base + 8'(i) * vecs[v].step));
         run_session($sformatf("vec%0d", v), vecs[v].sim_last, 1'b0, vecs[v].exp_writes);
      end

      // Latency: strobe driven before edge k gives ram_we in cycle k+3.
      clear_mon();
      ext_prog = 1'b1;
      cyc(4);
      ext_data   = 8'hA5;
      ext_strobe = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("lat_we_early", int'(ram_we), 0);
      @(posedge clk);
      @(negedge clk);
      check("lat_we_on", int'(ram_we), 1);
      check("lat_data", int'(ram_data), 8'hA5);
      check("lat_addr", int'(ram_addr), 0);
      @(negedge clk);
      check("lat_we_off", int'(ram_we), 0);
      ext_strobe = 1'b0;
      cyc(3);
      ext_prog = 1'b0;
      cyc(8);
      check("lat_count", int'(byte_count), 1);

      // Strobes while idle are ignored; done/byte_count persist.
      clear_mon();
      strobe_byte(8'hEE, 3, 3);
      strobe_byte(8'hDD, 3, 3);
      check("idle_nwrites", wr_q.size(), 0);
      check("idle_count", int'(byte_count), 1);
      check("idle_done", int'(done), 1);

      // Randomized sessions against the queue model.
      for (int r = 0; r < 6; r++) begin
         n = int'($urandom_range(0, 20));
         stim_q.delete();
         for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
         run_session($sformatf("rnd%0d", r), 1'b0, 1'b1, (n > 16) ? 16 : n);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
